// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory data-port arbiter.
// BAD_VAL marks error responses, store acks and disabled byte lanes.
package mem_arbiter_pkg;

  localparam int          MEM_SIZE_DEFAULT = 4096;
  localparam logic [31:0] BAD_VAL          = 32'hBADC_0FFE;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } arb_owner_e;

endpackage

// File: rtl/mem_req_check.sv
// Combinational legality check of one request: alignment for the access width and range against MEM_SIZE.
// Address arithmetic is widened to 33 bits so the end-of-access address cannot wrap.
module mem_req_check
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  output logic        ok
);

  logic [32:0] addr_x;
  logic [32:0] lim;

  assign addr_x = {1'b0, addr};
  assign lim    = 33'(MEM_SIZE);

  always_comb begin
    ok = 1'b0;
    case (be)
      4'b0001: ok = (addr_x < lim);
      4'b0011: ok = !addr[0] && ((addr_x + 33'd1) < lim);
      4'b1111: ok = (addr[1:0] == 2'b00) && ((addr_x + 33'd3) < lim);
      default: ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory data port between IFU and LSU: LSU priority, IFU wins after STARVE_LIMIT denied cycles.
// Grants are combinational; responses are registered and appear one cycle after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_SIZE     = MEM_SIZE_DEFAULT,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_req,
  input  logic [31:0] ifu_addr,
  output logic        ifu_gnt,
  output logic        ifu_rvalid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_be,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read_req,
  output logic        mem_write_req,
  output logic [3:0]  mem_byte_en,
  input  logic [31:0] mem_rdata_raw
);

  localparam int             SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STARVE_MAX = SW'(STARVE_LIMIT);

  arb_owner_e    owner;
  logic [SW-1:0] starve_cnt;
  logic          ifu_ok;
  logic          lsu_ok;

  mem_req_check #(.MEM_SIZE(MEM_SIZE)) u_ifu_check (
    .addr (ifu_addr),
    .be   (4'b1111),
    .ok   (ifu_ok)
  );

  mem_req_check #(.MEM_SIZE(MEM_SIZE)) u_lsu_check (
    .addr (lsu_addr),
    .be   (lsu_be),
    .ok   (lsu_ok)
  );

  // Reset gates ownership so no grant or memory write can occur while rst_n is low.
  always_comb begin
    owner = OWN_NONE;
    if (rst_n) begin
      if (ifu_req && lsu_req)
        owner = (starve_cnt == STARVE_MAX) ? OWN_IFU : OWN_LSU;
      else if (lsu_req)
        owner = OWN_LSU;
      else if (ifu_req)
        owner = OWN_IFU;
    end
  end

  assign ifu_gnt = (owner == OWN_IFU);
  assign lsu_gnt = (owner == OWN_LSU);

  always_comb begin
    mem_addr      = 32'd0;
    mem_wdata     = 32'd0;
    mem_byte_en   = 4'd0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    case (owner)
      OWN_IFU: begin
        mem_addr     = ifu_addr;
        mem_byte_en  = 4'b1111;
        mem_read_req = ifu_ok;
      end
      OWN_LSU: begin
        mem_addr      = lsu_addr;
        mem_wdata     = lsu_wdata;
        mem_byte_en   = lsu_be;
        mem_read_req  = lsu_ok && !lsu_we;
        mem_write_req = lsu_ok && lsu_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifu_rvalid <= 1'b0;
      ifu_rdata  <= BAD_VAL;
      ifu_err    <= 1'b0;
      lsu_rvalid <= 1'b0;
      lsu_rdata  <= BAD_VAL;
      lsu_err    <= 1'b0;
      starve_cnt <= '0;
    end else begin
      ifu_rvalid <= ifu_gnt;
      lsu_rvalid <= lsu_gnt;
      if (ifu_gnt) begin
        ifu_rdata <= ifu_ok ? mem_rdata_raw : BAD_VAL;
        ifu_err   <= !ifu_ok;
      end
      if (lsu_gnt) begin
        lsu_rdata <= (lsu_ok && !lsu_we) ? mem_rdata_raw : BAD_VAL;
        lsu_err   <= !lsu_ok;
      end
      if (ifu_gnt || !ifu_req)
        starve_cnt <= '0;
      else if (starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory environment plus an independent reference memory and rule-based model.
// Scenario tasks run in sequence and compare responses, grants and memory strobes inline.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int MEM    = 4096;
  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req, ifu_gnt, ifu_rvalid, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata_raw;
  logic        mem_read_req, mem_write_req;
  logic [3:0]  mem_byte_en;

  int checks = 0;
  int fails  = 0;

  logic [7:0] env_mem [0:MEM-1];
  logic [7:0] ref_mem [0:MEM-1];

  mem_arbiter #(.MEM_SIZE(MEM), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_byte_en(mem_byte_en), .mem_rdata_raw(mem_rdata_raw)
  );

  always #5 clk = ~clk;

  // Memory environment: combinational read, disabled or out-of-range lanes return BAD_VAL bits.
  function automatic logic [31:0] env_read(input logic [31:0] a, input logic [3:0] be);
    logic [31:0] r;
    longint      x;
    r = BAD_VAL;
    for (int k = 0; k < 4; k++) begin
      x = longint'(a) + k;
      if (be[k] && x < MEM) r[8*k +: 8] = env_mem[x];
    end
    return r;
  endfunction

  always_comb mem_rdata_raw = env_read(mem_addr, mem_byte_en);

  always @(posedge clk) begin
    if (rst_n && mem_write_req)
      for (int k = 0; k < 4; k++)
        if (mem_byte_en[k] && (longint'(mem_addr) + k) < MEM)
          env_mem[longint'(mem_addr) + k] <= mem_wdata[8*k +: 8];
  end

  // No write may be issued in a reset cycle.
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      checks++;
      if (mem_write_req !== 1'b0) begin
        fails++;
        $display("FAIL reset_no_write: mem_write_req=%b required 0", mem_write_req);
      end
    end
  end

  // Request fields must stay stable while a request waits for its grant.
  logic        l_held = 1'b0, i_held = 1'b0;
  logic [68:0] l_prev;
  logic [31:0] i_prev;
  always @(negedge clk) begin
    if (rst_n && l_held && lsu_req) begin
      checks++;
      if ({lsu_we, lsu_addr, lsu_wdata, lsu_be} !== l_prev) begin
        fails++;
        $display("FAIL lsu_req_stable: fields changed from %h to %h", l_prev, {lsu_we, lsu_addr, lsu_wdata, lsu_be});
      end
    end
    if (rst_n && i_held && ifu_req) begin
      checks++;
      if (ifu_addr !== i_prev) begin
        fails++;
        $display("FAIL ifu_req_stable: addr changed from %h to %h", i_prev, ifu_addr);
      end
    end
    l_held = rst_n && lsu_req && !lsu_gnt;
    i_held = rst_n && ifu_req && !ifu_gnt;
    l_prev = {lsu_we, lsu_addr, lsu_wdata, lsu_be};
    i_prev = ifu_addr;
  end

  // Reference model: legality from the access rules, byte-array memory, expected response word.
  function automatic void ref_access(input bit ifu, input bit we, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] be,
                                     output logic [31:0] rd, output bit er);
    logic [3:0] b;
    longint     base;
    bit         lg;
    b    = ifu ? 4'hF : be;
    base = longint'(a);
    case (b)
      4'h1:    lg = base < MEM;
      4'h3:    lg = (base % 2 == 0) && (base + 1 < MEM);
      4'hF:    lg = (base % 4 == 0) && (base + 3 < MEM);
      default: lg = 1'b0;
    endcase
    er = !lg;
    rd = BAD_VAL;
    if (lg && we && !ifu) begin
      for (int k = 0; k < 4; k++) if (b[k]) ref_mem[base + k] = wd[8*k +: 8];
    end else if (lg) begin
      for (int k = 0; k < 4; k++) if (b[k]) rd[8*k +: 8] = ref_mem[base + k];
    end
  endfunction

  // Issue one request from posedge+1; returns strobes at the grant and the two following response cycles.
  task automatic txn(input bit ifu, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output bit got, output logic rd, output logic wr,
                     output logic rv, output logic [31:0] rdat, output logic er, output logic rv2);
    got = 1'b0; rd = 1'b0; wr = 1'b0;
    if (ifu) begin
      ifu_req = 1'b1; ifu_addr = a;
    end else begin
      lsu_req = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_be = be;
    end
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if ((ifu ? ifu_gnt : lsu_gnt) === 1'b1) begin
        got = 1'b1; rd = mem_read_req; wr = mem_write_req;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    ifu_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk);
    rv   = ifu ? ifu_rvalid : lsu_rvalid;
    rdat = ifu ? ifu_rdata  : lsu_rdata;
    er   = ifu ? ifu_err    : lsu_err;
    @(posedge clk); #1;
    @(negedge clk);
    rv2 = ifu ? ifu_rvalid : lsu_rvalid;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bit got; logic rd, wr, rv, er, rv2; logic [31:0] rdat, exp; bit experr;
    ifu_req = 1'b1; ifu_addr = 32'h0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h10; lsu_wdata = 32'h5555_AAAA; lsu_be = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({ifu_gnt, lsu_gnt} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b required 00", {ifu_gnt, lsu_gnt}); end
    checks++; if ({mem_read_req, mem_write_req, mem_byte_en} !== 6'd0) begin fails++; $display("FAIL rst_mem_strobes: got %b required 0", {mem_read_req, mem_write_req, mem_byte_en}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin fails++; $display("FAIL rst_mem_bus: got %h required 0", {mem_addr, mem_wdata}); end
    checks++; if ({ifu_rvalid, lsu_rvalid, ifu_err, lsu_err} !== 4'd0) begin fails++; $display("FAIL rst_rsp_flags: got %b required 0000", {ifu_rvalid, lsu_rvalid, ifu_err, lsu_err}); end
    checks++; if (ifu_rdata !== BAD_VAL || lsu_rdata !== BAD_VAL) begin fails++; $display("FAIL rst_rdata: ifu %h lsu %h required %h", ifu_rdata, lsu_rdata, BAD_VAL); end
    ifu_req = 1'b0; lsu_req = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    // Reset in the grant cycle of a load and then of a store.
    for (int s = 0; s < 2; s++) begin
      lsu_we = 1'(s); lsu_addr = (s == 0) ? 32'h100 : 32'h300; lsu_wdata = 32'h1234_5678; lsu_be = 4'hF; lsu_req = 1'b1;
      @(negedge clk);
      checks++; if (lsu_gnt !== 1'b1) begin fails++; $display("FAIL rst_mid_gnt[%0d]: got %b required 1", s, lsu_gnt); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({lsu_gnt, mem_read_req, mem_write_req} !== 3'b000) begin fails++; $display("FAIL rst_mid_gate[%0d]: got %b required 000", s, {lsu_gnt, mem_read_req, mem_write_req}); end
      @(posedge clk); #1;
      checks++; if (lsu_rvalid !== 1'b0) begin fails++; $display("FAIL rst_mid_rvalid[%0d]: got %b required 0", s, lsu_rvalid); end
      checks++; if (lsu_rdata !== BAD_VAL) begin fails++; $display("FAIL rst_mid_rdata[%0d]: got %h required %h", s, lsu_rdata, BAD_VAL); end
      lsu_req = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
    end
    ref_access(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, exp, experr);
    txn(1'b0, 1'b0, 32'h300, 32'h0, 4'hF, got, rd, wr, rv, rdat, er, rv2);
    checks++; if (!got || rdat !== exp || er !== 1'b0) begin fails++; $display("FAIL rst_store_dropped: got %h err %b required %h err 0", rdat, er, exp); end
  endtask

  task automatic test_store_load();
    bit got; logic rd, wr, rv, er, rv2; logic [31:0] rdat, exp; bit experr;
    ref_access(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, exp, experr);
    txn(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, got, rd, wr, rv, rdat, er, rv2);
    checks++; if ({got, rd, wr} !== 3'b101) begin fails++; $display("FAIL st_strobes: gnt,rd,wr=%b required 101", {got, rd, wr}); end
    checks++; if ({rv, rv2, er} !== 3'b100 || rdat !== BAD_VAL) begin fails++; $display("FAIL st_ack: rv,rv2,err=%b rdata %h required 100 %h", {rv, rv2, er}, rdat, BAD_VAL); end
    txn(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, got, rd, wr, rv, rdat, er, rv2);
    checks++; if ({got, rd, wr} !== 3'b110) begin fails++; $display("FAIL ld_strobes: gnt,rd,wr=%b required 110", {got, rd, wr}); end
    checks++; if ({rv, rv2, er} !== 3'b100) begin fails++; $display("FAIL ld_flags: rv,rv2,err=%b required 100", {rv, rv2, er}); end
    checks++; if (rdat !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ld_data: got %h required deadbeef", rdat); end
  endtask

  task automatic test_contention();
    bit exp_i;
    ifu_addr = 32'h0; lsu_we = 1'b0; lsu_addr = 32'h10; lsu_be = 4'hF;
    ifu_req = 1'b1; lsu_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp_i = (c % 5 == 4);
      @(negedge clk);
      checks++;
      if (ifu_gnt !== exp_i || lsu_gnt !== !exp_i) begin
        fails++; $display("FAIL contention[%0d]: ifu_gnt %b lsu_gnt %b required %b %b", c, ifu_gnt, lsu_gnt, exp_i, !exp_i);
      end
      @(posedge clk); #1;
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    bit got; logic rd, wr, rv, er, rv2; logic [31:0] rdat;
    logic [31:0] addrs [3]; logic [3:0] bes [3]; bit wes [3];
    addrs = '{32'h101, 32'h100, 32'h102}; bes = '{4'b0011, 4'b0101, 4'b1111}; wes = '{1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 3; t++) begin
      txn(1'b0, wes[t], addrs[t], 32'hFFFF_FFFF, bes[t], got, rd, wr, rv, rdat, er, rv2);
      checks++; if ({got, rd, wr} !== 3'b100) begin fails++; $display("FAIL misalign_strobes[%0d]: gnt,rd,wr=%b required 100", t, {got, rd, wr}); end
      checks++; if ({rv, er} !== 2'b11 || rdat !== BAD_VAL) begin fails++; $display("FAIL misalign_rsp[%0d]: rv,err=%b rdata %h required 11 %h", t, {rv, er}, rdat, BAD_VAL); end
    end
  endtask

  task automatic test_bounds();
    bit got; logic rd, wr, rv, er, rv2; logic [31:0] rdat, exp; bit experr;
    logic [31:0] addrs [5]; bit ifus [5]; logic [3:0] bes [5]; bit errs [5];
    addrs = '{32'hFFC, 32'hFFE, 32'h1000, 32'hFFF, 32'hFFE};
    ifus  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bes   = '{4'hF, 4'hF, 4'hF, 4'h1, 4'h3};
    errs  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 5; t++) begin
      ref_access(ifus[t], 1'b0, addrs[t], 32'h0, bes[t], exp, experr);
      txn(ifus[t], 1'b0, addrs[t], 32'h0, bes[t], got, rd, wr, rv, rdat, er, rv2);
      checks++; if (!got || rv !== 1'b1 || er !== errs[t]) begin fails++; $display("FAIL bounds_err[%0d]: gnt %b rv %b err %b required 1 1 %b", t, got, rv, er, errs[t]); end
      checks++; if (rdat !== exp) begin fails++; $display("FAIL bounds_data[%0d]: got %h required %h", t, rdat, exp); end
    end
  endtask

  task automatic test_byte_store();
    bit got; logic rd, wr, rv, er, rv2; logic [31:0] rdat, exp; bit experr;
    ref_access(1'b0, 1'b1, 32'h203, 32'h0000_00AA, 4'h1, exp, experr);
    txn(1'b0, 1'b1, 32'h203, 32'h0000_00AA, 4'h1, got, rd, wr, rv, rdat, er, rv2);
    checks++; if ({got, wr, rv, er} !== 4'b1110) begin fails++; $display("FAIL byte_st: gnt,wr,rv,err=%b required 1110", {got, wr, rv, er}); end
    exp = {BAD_VAL[31:8], 8'hAA};
    txn(1'b0, 1'b0, 32'h203, 32'h0, 4'h1, got, rd, wr, rv, rdat, er, rv2);
    checks++; if (rdat !== exp || er !== 1'b0) begin fails++; $display("FAIL byte_ld: got %h err %b required %h err 0", rdat, er, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq [$];
    logic [31:0] e; bit ee;
    for (int i = 0; i < 8; i++) begin
      lsu_we = (i < 4); lsu_addr = 32'h500 + 32'(4 * (i % 4)); lsu_be = 4'hF;
      lsu_wdata = $urandom; lsu_req = 1'b1;
      ref_access(1'b0, lsu_we, lsu_addr, lsu_wdata, lsu_be, e, ee);
      expq.push_back(e);
      @(negedge clk);
      checks++; if (lsu_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b required 1", i, lsu_gnt); end
      if (i > 0) begin
        e = expq.pop_front();
        checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== e) begin fails++; $display("FAIL b2b_rsp[%0d]: rv %b rdata %h required 1 %h", i - 1, lsu_rvalid, lsu_rdata, e); end
      end
      @(posedge clk); #1;
    end
    lsu_req = 1'b0;
    @(negedge clk);
    e = expq.pop_front();
    checks++; if (lsu_rvalid !== 1'b1 || lsu_rdata !== e) begin fails++; $display("FAIL b2b_last: rv %b rdata %h required 1 %h", lsu_rvalid, lsu_rdata, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_random_txn();
    bit got, ifu, we, experr; logic rd, wr, rv, er, rv2; logic [31:0] rdat, exp, a, wd; logic [3:0] be;
    int r;
    for (int it = 0; it < 80; it++) begin
      ifu = ($urandom_range(0, 3) == 0);
      we  = !ifu && 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: be = 4'h1; 1: be = 4'h3; 2, 3: be = 4'hF; default: be = 4'($urandom);
      endcase
      r = $urandom_range(0, 9);
      if (r < 7)      a = 32'h400 + $urandom_range(0, 63);
      else if (r < 9) a = 32'hFF8 + $urandom_range(0, 11);
      else            a = $urandom;
      wd = $urandom;
      ref_access(ifu, we, a, wd, be, exp, experr);
      txn(ifu, we, a, wd, be, got, rd, wr, rv, rdat, er, rv2);
      checks++; if (got !== 1'b1) begin fails++; $display("FAIL rnd_gnt[%0d]: no grant within budget", it); end
      checks++; if ({rd, wr} !== {!experr && !we, !experr && we}) begin fails++; $display("FAIL rnd_strobes[%0d]: rd,wr=%b%b required %b%b", it, rd, wr, !experr && !we, !experr && we); end
      checks++; if ({rv, rv2} !== 2'b10) begin fails++; $display("FAIL rnd_rvalid[%0d]: rv,rv2=%b%b required 10", it, rv, rv2); end
      checks++; if (er !== experr) begin fails++; $display("FAIL rnd_err[%0d]: got %b required %b (addr %h be %b)", it, er, experr, a, be); end
      checks++; if (rdat !== exp) begin fails++; $display("FAIL rnd_data[%0d]: got %h required %h (addr %h be %b)", it, rdat, exp, a, be); end
    end
  endtask

  task automatic test_random_arb();
    bit ir, lr, ig, lg, pend_l, prev_i, prev_l;
    int denied;
    denied = 0; pend_l = 0; prev_i = 0; prev_l = 0;
    ifu_addr = 32'h40; lsu_we = 1'b0; lsu_addr = 32'h80; lsu_be = 4'hF;
    for (int c = 0; c < 60; c++) begin
      ir = 1'($urandom_range(0, 3) != 0);
      lr = pend_l ? 1'b1 : 1'($urandom_range(0, 4) != 0);
      ifu_req = ir; lsu_req = lr;
      ig = ir && (!lr || denied == STARVE);
      lg = lr && !ig;
      @(negedge clk);
      checks++; if ({ifu_gnt, lsu_gnt} !== {ig, lg}) begin fails++; $display("FAIL arb_gnt[%0d]: got %b%b required %b%b", c, ifu_gnt, lsu_gnt, ig, lg); end
      checks++; if ({ifu_rvalid, lsu_rvalid} !== {prev_i, prev_l}) begin fails++; $display("FAIL arb_rvalid[%0d]: got %b%b required %b%b", c, ifu_rvalid, lsu_rvalid, prev_i, prev_l); end
      denied = (ir && !ig) ? ((denied < STARVE) ? denied + 1 : STARVE) : 0;
      pend_l = lr && !lg;
      prev_i = ig; prev_l = lg;
      @(posedge clk); #1;
    end
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (2) @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] b;
    rst_n = 1'b0; ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = '0;
    for (int i = 0; i < MEM; i++) begin
      b = 8'($urandom);
      env_mem[i] = b; ref_mem[i] = b;
    end
    test_reset();
    test_store_load();
    test_contention();
    test_misalign();
    test_bounds();
    test_byte_store();
    test_back_to_back();
    test_random_txn();
    test_random_arb();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data port of the unified byte-addressed memory model between two requesters: instruction fetch (IFU) and load/store unit (LSU).
- Each requester uses a req/gnt handshake; responses are registered and return one cycle after grant.
- Arbitration is LSU-priority with a starvation guard for IFU.
- Alignment and range checks happen before the memory is touched.

Parameters:
- MEM_SIZE, 4096: memory size in bytes; accesses whose last byte is at or beyond this address are errors.
- STARVE_LIMIT, 4: number of consecutive denied IFU cycles after which IFU wins arbitration.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_req  in  1  fetch request; held with ifu_addr stable until ifu_gnt
- ifu_addr  in  32  fetch byte address
- ifu_gnt  out  1  fetch accepted this cycle (combinational)
- ifu_rvalid  out  1  fetch response valid (registered)
- ifu_rdata  out  32  fetch word
- ifu_err  out  1  fetch error, qualified by ifu_rvalid
- lsu_req  in  1  data request; held stable with all lsu_* inputs until lsu_gnt
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  32  data byte address
- lsu_wdata  in  32  store data, lane k maps to byte addr+k
- lsu_be  in  4  byte enables
- lsu_gnt  out  1  data request accepted this cycle (combinational)
- lsu_rvalid  out  1  load data or store ack valid (registered)
- lsu_rdata  out  32  load data
- lsu_err  out  1  access error, qualified by lsu_rvalid
- mem_addr  out  32  to memory data port
- mem_wdata  out  32  to memory
- mem_read_req  out  1  to memory
- mem_write_req  out  1  to memory
- mem_byte_en  out  4  to memory
- mem_rdata_raw  in  32  combinational read data from memory

Behaviour:
- Owner selection, combinational from req and starve_cnt:
  - Both requesting: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
  - Only one requesting: that requester wins.
  - At most one grant per cycle.
- Legality check per request:
  - IFU: addr[1:0] == 0 and addr+3 < MEM_SIZE.
  - LSU be=0001: addr < MEM_SIZE.
  - LSU be=0011: addr[0] == 0 and addr+1 < MEM_SIZE.
  - LSU be=1111: addr[1:0] == 0 and addr+3 < MEM_SIZE.
  - Any other be pattern is illegal.
  - Address-plus-offset arithmetic is 33-bit so it cannot wrap.
- Granted legal request, same cycle:
  - mem_addr, mem_wdata and mem_byte_en are driven from the owner.
  - Load or fetch: mem_read_req=1.
  - Store: mem_write_req=1; the write commits at this clk edge.
- Granted illegal request: consumes the grant slot; mem_read_req and mem_write_req stay 0.
- No grant: mem_read_req=0, mem_write_req=0, mem_addr=0, mem_wdata=0, mem_byte_en=0.
- Response, registered at the grant edge, visible the following cycle:
  - The owner's rvalid=1 for exactly one cycle.
  - rdata = mem_rdata_raw for a legal read; BAD_VAL for a store ack or an error.
  - err=1 for an illegal request.
  - Disabled byte lanes come back as BAD_VAL bits, passed through from memory.
- Back-to-back: a new grant may occur in the same cycle an rvalid is asserted; throughput is one access per cycle.
- starve_cnt, 0..STARVE_LIMIT, saturating:
  - +1 on ifu_req && !ifu_gnt.
  - Cleared on ifu_gnt or !ifu_req.
- Reset (async, rst_n=0):
  - ifu_rvalid=0, lsu_rvalid=0, ifu_err=0, lsu_err=0, ifu_rdata=BAD_VAL, lsu_rdata=BAD_VAL, starve_cnt=0.
  - All mem_* outputs are 0 and both gnts are 0 while rst_n=0.
  - A pending response is dropped; no write is issued in a reset cycle.
- Requester dropping req before gnt: legal, no side effect. Changing request fields while req is held: undefined, flagged by a BENCH-only assertion.

Decomposition:
- typepkg gains:
  - arb_owner_e {OWN_NONE, OWN_IFU, OWN_LSU}.
  - Shared constant MEM_SIZE_DEFAULT=4096.
  - Existing BAD_VAL is reused.
- Sub-module mem_req_check: combinational legality check (addr, be, MEM_SIZE parameter → ok). Instanced twice: IFU with be forced to 1111, and LSU.

Test Plan:
1. Reset: rst_n=0 mid-load (lsu_gnt cycle) → next cycle lsu_rvalid=0, lsu_rdata=BAD_VAL, no mem_write_req ever seen.
2. Store then load: LSU store addr=0x100 be=1111 wdata=0xDEADBEEF; next request load 0x100 be=1111 → lsu_rvalid 1 cycle after each gnt, load rdata=0xDEADBEEF, err=0.
3. Contention: ifu_req and lsu_req held high 8 cycles, STARVE_LIMIT=4 → LSU granted cycles 0-3, IFU granted cycle 4, starve_cnt then returns to 0.
4. Misalignment: LSU be=0011 addr=0x101 → lsu_gnt=1, mem_read_req=0, next cycle lsu_err=1, lsu_rdata=BAD_VAL. Same for be=0101 at addr=0x100.
5. Bounds: IFU addr=0xFFC → legal, ifu_err=0. IFU addr=0xFFE and addr=0x1000 → ifu_err=1. LSU be=0001 addr=0xFFF → legal.
6. Byte store: store be=0001 addr=0x203 wdata=0x000000AA, then load be=0001 addr=0x203 → rdata[7:0]=0xAA, rdata[31:8]=BAD_VAL[31:8].
